add_sched: RTL and testbench



---
 rtl/add_pkg.sv | 11 +
 rtl/add.sv | 10 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/add_sched.sv | 121 ++++++++++++
 tb/tb_add_sched.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// Shared types and widths for the add_sched block and the add datapath it wraps.
package add_pkg;
  localparam int DATA_W = 4;
  localparam int SUM_W  = DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } add_sched_state_t;
endpackage

// File: rtl/add.sv
// Shared combinational unsigned adder; the carry is kept so the sum never truncates.
module add
  import add_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [SUM_W-1:0]  sum
);
  assign sum = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above last_id, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_id,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IDW-1:0]  grant_id
);
  logic [IDW-1:0] idx_s;
  logic           found_s;
  logic           take_s;

  // Scan NREQ positions starting just after last_id; the first asserted request wins.
  always_comb begin
    grant_onehot = '0;
    grant_id     = '0;
    idx_s        = '0;
    found_s      = 1'b0;
    take_s       = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s               = IDW'((int'(last_id) + k) % NREQ);
      take_s              = req[idx_s] & ~found_s;
      grant_onehot[idx_s] = take_s;
      grant_id            = take_s ? idx_s : grant_id;
      found_s             = found_s | take_s;
    end
  end
endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one add instance among NREQ requesters,
// returning each registered sum tagged with its requester id.
module add_sched #(
  parameter int NREQ   = 4,
  parameter int DATA_W = add_pkg::DATA_W,
  parameter int SUM_W  = DATA_W + 1,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [SUM_W-1:0]       rsp_sum,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
);
  import add_pkg::*;

  add_sched_state_t  state_r, state_next_s;
  logic [IDW-1:0]    last_id_r, cur_id_r, grant_id_s, rsp_id_r;
  logic [NREQ-1:0]   grant_onehot_s;
  logic [DATA_W-1:0] op_a_r, op_b_r, sel_a_s, sel_b_s;
  logic [SUM_W-1:0]  add_sum_s, rsp_sum_r;
  logic              rsp_valid_r, busy_r, any_req_s;

  assign any_req_s = |req_valid;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req          (req_valid),
    .last_id      (last_id_r),
    .grant_onehot (grant_onehot_s),
    .grant_id     (grant_id_s)
  );

  add u_add (
    .a   (op_a_r),
    .b   (op_b_r),
    .sum (add_sum_s)
  );

  // One-hot grant acts as an AND-OR mux over the packed operand buses.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a_s = sel_a_s | (req_a[i*DATA_W +: DATA_W] & {DATA_W{grant_onehot_s[i]}});
      sel_b_s = sel_b_s | (req_b[i*DATA_W +: DATA_W] & {DATA_W{grant_onehot_s[i]}});
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_next_s = CALC;
        else           state_next_s = IDLE;
      end
      CALC: state_next_s = RESP;
      RESP: begin
        if (rsp_ready) state_next_s = IDLE;
        else           state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Grant is offered only in IDLE and is forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_r == IDLE && !rst) req_ready = grant_onehot_s;
    else                         req_ready = '0;
  end

  // State, operand capture, result register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      last_id_r   <= IDW'(NREQ - 1);
      cur_id_r    <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      rsp_sum_r   <= '0;
      rsp_id_r    <= '0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      rsp_valid_r <= (state_next_s == RESP);
      busy_r      <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            op_a_r   <= sel_a_s;
            op_b_r   <= sel_b_s;
            cur_id_r <= grant_id_s;
          end
        end
        CALC: begin
          rsp_sum_r <= add_sum_s;
          rsp_id_r  <= cur_id_r;
        end
        RESP: begin
          if (rsp_ready) last_id_r <= cur_id_r;
        end
        default: begin
          last_id_r <= IDW'(NREQ - 1);
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_id    = rsp_id_r;
  assign busy      = busy_r;
endmodule

// File: tb/tb_add_sched.sv
// Self-checking bench for add_sched: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_add_sched;
  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int SW   = 5;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*DW-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [SW-1:0]     rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  always #5 clk = ~clk;

  add_sched #(.NREQ(NREQ), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Transaction model: one outstanding job, its age in cycles, and the last served id.
  bit m_pend = 1'b0;
  int m_age  = 0;
  int m_a = 0, m_b = 0, m_id = 0;
  int m_last = NREQ - 1;
  int mdl_pick;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (v[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  always_comb mdl_pick = rr_pick(req_valid, m_last);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_age  <= 0;
      m_last <= NREQ - 1;
    end else if (!m_pend) begin
      if (mdl_pick >= 0) begin
        m_pend <= 1'b1;
        m_age  <= 0;
        m_a    <= int'(req_a[mdl_pick*DW +: DW]);
        m_b    <= int'(req_b[mdl_pick*DW +: DW]);
        m_id   <= mdl_pick;
      end
    end else if (m_age == 0) begin
      m_age <= 1;
    end else if (rsp_ready) begin
      m_last <= m_id;
      m_pend <= 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("req_ready", req_ready,
        (!m_pend && !rst && mdl_pick >= 0) ? (32'd1 << mdl_pick) : 32'd0);
    chk("busy", busy, m_pend);
    chk("rsp_valid", rsp_valid, m_pend && m_age == 1);
    if (m_pend && m_age == 1) begin
      chk("rsp_sum", rsp_sum, m_a + m_b);
      chk("rsp_id", rsp_id, m_id);
    end
  end

  // Grant and response logs for the directed scenarios.
  int g_q[$];
  int r_id_q[$], r_sum_q[$], r_cyc_q[$];
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) g_q.push_back(i);
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      r_id_q.push_back(int'(rsp_id));
      r_sum_q.push_back(int'(rsp_sum));
      r_cyc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*DW +: DW] = DW'(a);
    req_b[i*DW +: DW] = DW'(b);
    req_valid[i]      = 1'b1;
  endtask

  task automatic one_txn(input string name, input int i, input int a, input int b,
                         input int exp_sum);
    set_req(i, a, b);
    @(negedge clk);
    chk({name, "_ready"}, req_ready, 32'd1 << i);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk({name, "_calc_valid"}, rsp_valid, 1'b0);
    @(negedge clk);
    chk({name, "_valid"}, rsp_valid, 1'b1);
    chk({name, "_sum"}, rsp_sum, exp_sum);
    chk({name, "_id"}, rsp_id, i);
    tick();
  endtask

  // Clear each requester's valid on the edge after it was granted.
  task automatic serve(input int n);
    logic [NREQ-1:0] r;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      r = req_ready;
      tick();
      req_valid = req_valid & ~r;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g[4];
    int exp_s[4];
    int n;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #7;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", rsp_sum, 5'd0);
    chk("rst_id", rsp_id, 2'd0);
    chk("rst_ready", req_ready, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;

    one_txn("single", 2, 4, 4, 8);
    one_txn("maxop", 0, 15, 15, 30);

    // All four contend from a fresh reset: order 0,1,2,3, one every 3 cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    g_q.delete(); r_id_q.delete(); r_sum_q.delete(); r_cyc_q.delete();
    set_req(0, 1, 1); set_req(1, 2, 2); set_req(2, 3, 3); set_req(3, 4, 4);
    serve(14);
    req_valid = '0;
    exp_g = '{0, 1, 2, 3};
    exp_s = '{2, 4, 6, 8};
    chk("all_rsp_count", r_id_q.size(), 4);
    n = (g_q.size() < 4) ? g_q.size() : 4;
    for (int k = 0; k < n; k++) chk("all_grant_order", g_q[k], exp_g[k]);
    n = (r_id_q.size() < 4) ? r_id_q.size() : 4;
    for (int k = 0; k < n; k++) begin
      chk("all_rsp_id", r_id_q[k], exp_g[k]);
      chk("all_rsp_sum", r_sum_q[k], exp_s[k]);
      if (k > 0) chk("all_spacing", r_cyc_q[k] - r_cyc_q[k-1], 3);
    end

    // Backpressure: requester 1 served, held 5 cycles; requester 3 waits.
    rsp_ready = 1'b0;
    set_req(1, 5, 6); set_req(3, 2, 7);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_resp", rsp_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_sum", rsp_sum, 11);
      chk("bp_id", rsp_id, 1);
      chk("bp_ready", req_ready, 4'd0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", rsp_valid, 1'b1);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Fairness between two continuous requesters.
    g_q.delete();
    set_req(1, 1, 2); set_req(3, 3, 4);
    repeat (13) tick();
    req_valid = '0;
    repeat (4) tick();
    exp_g = '{1, 3, 1, 3};
    chk("fair_count_ok", g_q.size() >= 4, 1'b1);
    n = (g_q.size() < 4) ? g_q.size() : 4;
    for (int k = 0; k < n; k++) chk("fair_order", g_q[k], exp_g[k]);

    // Reset during CALC.
    set_req(2, 7, 7);
    tick();
    req_valid = '0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", req_ready, 4'd0);
    tick(); tick();
    rst = 1'b0;
    r_id_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale_valid", rsp_valid, 1'b0);
    end
    chk("no_stale_count", r_id_q.size(), 0);
    tick();
    set_req(0, 1, 1); set_req(2, 2, 2);
    @(negedge clk);
    chk("post_rst_prio", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
